// File: rtl/gate_array_pipe.sv
// gate_array_pipe: registered WIDTH-bit gate array with valid/ready handshakes, accumulator chaining and flags.
// Optional build macro GATE_ARRAY_POPCOUNT_EN adds the registered out_popcount output.
module gate_array_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
`ifdef GATE_ARRAY_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] out_popcount,
`endif
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] txn_count
);
    logic [WIDTH-1:0] opa, res_d, data_q, acc_q;
    logic             valid_q, zero_q, ones_q, par_q, accept;
    logic [CNT_W-1:0] cnt_q;

    assign in_ready   = !valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign opa        = acc_sel ? acc_q : a;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign out_parity = par_q;
    assign acc        = acc_q;
    assign txn_count  = cnt_q;

    // bitwise gate selected by op; NOT ignores b, PASS ignores operand A
    always_comb begin
        res_d = '0;
        case (op)
            3'd0: res_d = opa & b;
            3'd1: res_d = opa | b;
            3'd2: res_d = ~opa;
            3'd3: res_d = ~(opa & b);
            3'd4: res_d = ~(opa | b);
            3'd5: res_d = opa ^ b;
            3'd6: res_d = ~(opa ^ b);
            default: res_d = b;
        endcase
    end

    // result register, flags, counter and accumulator; flags only change with the data they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            ones_q  <= 1'b0;
            par_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                data_q <= res_d;
                zero_q <= res_d == '0;
                ones_q <= &res_d;
                par_q  <= ^res_d;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            valid_q <= accept || (valid_q && !out_ready);
            if (acc_clr)
                acc_q <= '0;
            else if (accept && acc_sel)
                acc_q <= res_d;
        end
    end

`ifdef GATE_ARRAY_POPCOUNT_EN
    localparam int PC_W = $clog2(WIDTH + 1);
    logic [PC_W-1:0] pc_d, pc_q;
    assign out_popcount = pc_q;

    // number of set bits in the candidate result
    always_comb begin
        pc_d = '0;
        for (int i = 0; i < WIDTH; i++)
            pc_d = pc_d + PC_W'(res_d[i]);
    end

    // popcount register follows out_data exactly
    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= '0;
        else if (accept)
            pc_q <= pc_d;
    end
`endif
endmodule

// File: tb/tb_gate_array_pipe.sv
// tb_gate_array_pipe: directed and random checks of gate_array_pipe against a transaction-level model.
module tb_gate_array_pipe;
    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, in_valid = 1'b0, acc_sel = 1'b0, acc_clr = 1'b0, out_ready = 1'b0;
    logic [2:0] op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, out_zero, out_ones, out_parity;
    logic [W-1:0] out_data, acc;
    logic [C-1:0] txn_count;
`ifdef GATE_ARRAY_POPCOUNT_EN
    logic [$clog2(W+1)-1:0] out_popcount;
`endif

    always #5 clk = ~clk;

    gate_array_pipe #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .acc_sel(acc_sel), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
        .out_ones(out_ones), .out_parity(out_parity),
`ifdef GATE_ARRAY_POPCOUNT_EN
        .out_popcount(out_popcount),
`endif
        .acc(acc), .txn_count(txn_count)
    );

    int errors = 0, checks = 0;

    // transaction-level model
    logic [W-1:0] m_data, m_acc, m_r;
    logic m_valid, m_has;
    logic m_init = 1'b0;
    int unsigned m_cnt;

    function automatic logic [W-1:0] gate(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return ~x;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return x ^ y;
            3'd6: return ~(x ^ y);
            default: return y;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_data = '0; m_acc = '0; m_valid = 1'b0; m_has = 1'b0; m_cnt = 0; m_init = 1'b1;
        end else if (m_init) begin
            m_r = gate(op, acc_sel ? m_acc : a, b);
            if (in_valid && (!m_valid || out_ready)) begin
                m_data = m_r; m_valid = 1'b1; m_has = 1'b1;
                m_cnt = (m_cnt + 1) % (1 << C);
                if (acc_sel) m_acc = m_r;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc_clr) m_acc = '0;
        end
    end

    // hand-computed literal expectations, armed by the stimulus for one cycle
    logic l_data_on = 0, l_acc_on = 0, l_cnt_on = 0, l_flg_on = 0, l_rdy_on = 0, l_vld_on = 0;
    logic [W-1:0] l_data, l_acc;
    logic [C-1:0] l_cnt;
    logic [2:0] l_flg;
    logic l_rdy, l_vld;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", n, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("acc", 32'(acc), 32'(m_acc));
            chk("txn_count", 32'(txn_count), m_cnt);
            chk("out_zero", 32'(out_zero), 32'(m_has && m_data == '0));
            chk("out_ones", 32'(out_ones), 32'(&m_data));
            chk("out_parity", 32'(out_parity), 32'(^m_data));
`ifdef GATE_ARRAY_POPCOUNT_EN
            chk("out_popcount", 32'(out_popcount), 32'($countones(m_data)));
`endif
            if (l_data_on) chk("lit_data", 32'(out_data), 32'(l_data));
            if (l_acc_on) chk("lit_acc", 32'(acc), 32'(l_acc));
            if (l_cnt_on) chk("lit_count", 32'(txn_count), 32'(l_cnt));
            if (l_flg_on) chk("lit_flags", 32'({out_zero, out_ones, out_parity}), 32'(l_flg));
            if (l_rdy_on) chk("lit_in_ready", 32'(in_ready), 32'(l_rdy));
            if (l_vld_on) chk("lit_out_valid", 32'(out_valid), 32'(l_vld));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        l_data_on = 0; l_acc_on = 0; l_cnt_on = 0; l_flg_on = 0; l_rdy_on = 0; l_vld_on = 0;
    endtask

    task automatic lit_data(input logic [W-1:0] v);
        l_data = v; l_data_on = 1;
    endtask

    logic [W-1:0] tt [8];

    initial begin
        tt = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'hCC};
        rst = 1; tick; tick;
        l_vld = 0; l_vld_on = 1; l_cnt = 0; l_cnt_on = 1; l_flg = 3'b000; l_flg_on = 1;
        rst = 0; out_ready = 1;
        // truth-table sweep
        in_valid = 1; a = 8'hF0; b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick;
            lit_data(tt[i]);
            if (i == 7) begin l_cnt = 8; l_cnt_on = 1; end
        end
        // flags
        op = 0; a = 8'h0F; b = 8'hF0; tick; lit_data(8'h00); l_flg = 3'b100; l_flg_on = 1;
        op = 1; tick; lit_data(8'hFF); l_flg = 3'b010; l_flg_on = 1;
        op = 7; b = 8'h07; tick; lit_data(8'h07); l_flg = 3'b001; l_flg_on = 1;
        // backpressure
        in_valid = 0; tick;
        out_ready = 0; in_valid = 1; op = 5; a = 8'h12; b = 8'h34; tick; lit_data(8'h26);
        op = 1; a = 8'h50; b = 8'h05;
        for (int i = 0; i < 5; i++) begin
            tick; lit_data(8'h26); l_rdy = 0; l_rdy_on = 1; l_vld = 1; l_vld_on = 1;
        end
        tick;
        out_ready = 1; tick; lit_data(8'h55); l_vld = 1; l_vld_on = 1;
        in_valid = 0; tick; l_vld = 0; l_vld_on = 1;
        // accumulator chain
        in_valid = 1; acc_sel = 1; op = 7; b = 8'hAA; tick; lit_data(8'hAA); l_acc = 8'hAA; l_acc_on = 1;
        op = 5; b = 8'hFF; tick; lit_data(8'h55); l_acc = 8'h55; l_acc_on = 1;
        acc_clr = 1; b = 8'h0F; tick; lit_data(8'h5A); l_acc = 8'h00; l_acc_on = 1;
        acc_clr = 0; acc_sel = 0; in_valid = 0; tick;
        // reset mid-operation
        rst = 1; tick; rst = 0;
        out_ready = 1; in_valid = 1; acc_sel = 1; op = 7; b = 8'h05;
        tick; tick; tick; l_cnt = 3; l_cnt_on = 1; l_acc = 8'h05; l_acc_on = 1;
        out_ready = 0; acc_sel = 0; tick; l_cnt = 3; l_cnt_on = 1; l_vld = 1; l_vld_on = 1;
        rst = 1; tick; l_vld = 0; l_vld_on = 1; l_acc = 0; l_acc_on = 1; l_cnt = 0; l_cnt_on = 1;
        rst = 0; in_valid = 0; tick;
        // counter wrap with CNT_W=4
        rst = 1; tick; rst = 0;
        out_ready = 1; in_valid = 1; op = 6;
        for (int i = 0; i < 17; i++) tick;
        l_cnt = 1; l_cnt_on = 1;
        in_valid = 0; tick;
        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            op = 3'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            acc_sel = 1'($urandom);
            acc_clr = ($urandom % 8) == 0;
            rst = ($urandom % 50) == 0;
            tick;
        end
        rst = 0; in_valid = 0; acc_clr = 0; tick;
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
